alu_cmd_engine: RTL and testbench
=================================

ALU_CMD_ENGINE -- requirements
Module: alu_cmd_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 The block SHALL have parameter DEPTH, default 2, response FIFO depth in entries (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 not.
REQ-008 cmd_a, cmd_b  input  WIDTH each  operands.
REQ-009 cmd_use_acc  input  1  use accumulator in place of cmd_a.
REQ-010 rsp_valid  output  1  response at FIFO head.
REQ-011 rsp_ready  input  1  consumer takes response.
REQ-012 rsp_result  output  WIDTH  result; rsp_carry  output  1  carry/borrow; rsp_zero  output  1  result == 0.
REQ-013 acc  output  WIDTH  current accumulator value.

Function
REQ-014 A command SHALL be accepted exactly on cycles where cmd_valid && cmd_ready.
REQ-015 cmd_ready SHALL equal (FIFO occupancy < DEPTH), registered-state derived, independent of cmd_valid and rsp_ready.
REQ-016 Operand A SHALL be acc when cmd_use_acc=1, else cmd_a; operand B is always cmd_b.
REQ-017 add: {carry,result} = A+B as WIDTH+1 bits; sub: {carry,result} = A-B as WIDTH+1 bits (carry=1 means borrow).
REQ-018 All other opcodes SHALL produce carry=0; shl1/shr1 are logical, fill 0; not is bitwise ~A.
REQ-019 zero SHALL be 1 iff result is all zeros, for every opcode.
REQ-020 On acceptance, {result,carry,zero} SHALL be pushed into the FIFO and acc SHALL load result at the same clock edge.
REQ-021 Latency: response SHALL appear (rsp_valid=1) in the cycle after acceptance if the FIFO was empty.
REQ-022 rsp_valid SHALL be 1 iff occupancy > 0; a pop occurs on rsp_valid && rsp_ready.
REQ-023 rsp_* data SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-025 At full, cmd_ready=0; a pop at full raises cmd_ready in the following cycle, not the same cycle.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-027 Responses SHALL be delivered strictly in command order.

Reset
REQ-028 rst_n low SHALL immediately clear: occupancy 0, pointers 0, acc 0, rsp_valid 0, cmd_ready 1 (after release), rsp_result/carry/zero 0.
REQ-029 Reset mid-operation SHALL discard all buffered responses; no response SHALL emerge after reset for pre-reset commands.

Configuration
REQ-030 Macro ALU_CMD_ENGINE_STATS_EN defined: adds output op_count (16 bits), incremented on each pop, saturating at 16'hFFFF, reset to 0.
REQ-031 Macro undefined: op_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-032 Opcode encodings (3-bit localparams for the eight ops) SHALL live in shared package alu_pkg, also used by the existing ALU.
REQ-033 The response buffer SHALL be sub-module alu_rsp_fifo (parameters WIDTH+2 data width, DEPTH); opcode evaluation stays combinational in alu_cmd_engine.

Verification
REQ-034 Reset then add A=32'hFFFF_FFFF,B=1 -> next cycle rsp_result=0, rsp_carry=1, rsp_zero=1, acc=0.
REQ-035 sub A=5,B=7 -> rsp_result=32'hFFFF_FFFE, rsp_carry=1, rsp_zero=0; xor A=B=32'hA5A5_A5A5 -> result 0, carry 0, zero 1.
REQ-036 Accumulate chain: add cmd_a=3,B=4; then cmd_use_acc=1 add B=10; then shl1 use_acc -> results 7, 17, 34 in order.
REQ-037 Backpressure: rsp_ready=0, issue 3 commands -> first two accepted, cmd_ready=0 on third; release rsp_ready -> all three delivered in order, data stable while stalled.
REQ-038 Assert rst_n=0 with 2 entries buffered -> rsp_valid=0 immediately, acc=0; after release no stale response appears.
REQ-039 With ALU_CMD_ENGINE_STATS_EN: 5 pops -> op_count=5; without it, build compiles with no op_count port.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by the existing ALU and alu_cmd_engine.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous response FIFO, DEPTH entries (power of two) of DW bits.
//   push_i/wdata_i : write, ignored when full (ready_o=0)
//   pop_i          : read, ignored when empty (valid_o=0)
//   valid_o        : occupancy > 0; rdata_o is the head entry, zero when empty
//   ready_o        : occupancy < DEPTH, from registered state only
module alu_rsp_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic          ready_o,
    output logic [DW-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign valid_o = cnt_q != '0;
    assign ready_o = cnt_q < FULL;
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: rdata_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: accumulator ALU with a command handshake and buffered responses.
//   cmd_valid/cmd_ready : command handshake; cmd_op, cmd_a, cmd_b, cmd_use_acc
//   rsp_valid/rsp_ready : response handshake; rsp_result, rsp_carry, rsp_zero
//   acc                 : accumulator, loaded with every accepted result
//   op_count            : pop counter (saturating), only with ALU_CMD_ENGINE_STATS_EN
module alu_cmd_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc
`ifdef ALU_CMD_ENGINE_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);
    logic [WIDTH-1:0] acc_q, acc_d, opa, res;
    logic [WIDTH:0]   ext;
    logic             push, carry, zero;
    assign opa = cmd_use_acc ? acc_q : cmd_a;
    // ext carries {carry,result}; only add/sub can set the top bit.
    always_comb begin
        ext = '0;
        case (cmd_op)
            OP_ADD:  ext = {1'b0, opa} + {1'b0, cmd_b};
            OP_SUB:  ext = {1'b0, opa} - {1'b0, cmd_b};
            OP_AND:  ext = {1'b0, opa & cmd_b};
            OP_OR:   ext = {1'b0, opa | cmd_b};
            OP_XOR:  ext = {1'b0, opa ^ cmd_b};
            OP_SHL:  ext = {1'b0, opa[WIDTH-2:0], 1'b0};
            OP_SHR:  ext = {2'b00, opa[WIDTH-1:1]};
            default: ext = {1'b0, ~opa};
        endcase
    end
    assign res   = ext[WIDTH-1:0];
    assign carry = ext[WIDTH];
    assign zero  = ~|res;
    assign push  = cmd_valid && cmd_ready;
    assign acc_d = push ? res : acc_q;
    assign acc   = acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else acc_q <= acc_d;
    end
    alu_rsp_fifo #(.DW(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({res, carry, zero}),
        .pop_i   (rsp_ready),
        .valid_o (rsp_valid),
        .ready_o (cmd_ready),
        .rdata_o ({rsp_result, rsp_carry, rsp_zero})
    );
`ifdef ALU_CMD_ENGINE_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d    = (rsp_valid && rsp_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    assign op_count = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: scoreboard bench for alu_cmd_engine (WIDTH=32, DEPTH=2).
module tb_alu_cmd_engine;
    import alu_pkg::*;
    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_use_acc = 0;
    logic [2:0]  cmd_op = 0;
    logic [31:0] cmd_a = 0, cmd_b = 0, rsp_result, acc;
    logic        rsp_valid, rsp_ready = 1, rsp_carry, rsp_zero;
`ifdef ALU_CMD_ENGINE_STATS_EN
    logic [15:0] op_count;
`endif
    always #5 clk = ~clk;

    alu_cmd_engine #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc)
`ifdef ALU_CMD_ENGINE_STATS_EN
        , .op_count(op_count)
`endif
    );

    int errs = 0, checks = 0, pops = 0, exp_occ = 0;
    logic [33:0] q[$];
    logic [31:0] acc_m = 0;
    logic done = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {result, carry, zero} from plain arithmetic.
    function automatic logic [33:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        c;
        longint      s;
        c = 0;
        r = 0;
        case (op)
            OP_ADD: begin s = longint'(a) + longint'(b); r = s[31:0]; c = s[32]; end
            OP_SUB: begin r = a - b; c = a < b; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a * 2;
            OP_SHR: r = a / 2;
            default: r = ~a;
        endcase
        return {r, c, r == 0};
    endfunction

    // Monitor: checks handshake outputs against expected occupancy and the head data.
    always @(negedge clk) begin
        logic popped;
        if (!rst_n) begin
            exp_occ = 0;
            pops = 0;
            q.delete();
        end else begin
            chk("rsp_valid", rsp_valid, exp_occ > 0);
            chk("cmd_ready", cmd_ready, exp_occ < 2);
            popped = exp_occ > 0 && rsp_ready;
            if (exp_occ > 0) begin
                if (q.size() == 0) chk("scoreboard_nonempty", 0, 1);
                else chk("rsp_data", {rsp_result, rsp_carry, rsp_zero}, q[0]);
            end else begin
                chk("rsp_idle_zero", {rsp_result, rsp_carry, rsp_zero}, 0);
            end
            if (popped) begin
                if (q.size() > 0) void'(q.pop_front());
                pops++;
            end
            exp_occ += int'(cmd_valid && exp_occ < 2) - int'(popped);
        end
    end

    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic ua);
        logic [33:0] e;
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e = model(op, ua ? acc_m : a, b);
                q.push_back(e);
                acc_m = e[33:2];
                @(posedge clk);
                #1;
                cmd_valid = 0;
                chk("acc", acc, acc_m);
                return;
            end
        end
        chk("issue_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cycles(3);
        rst_n = 1;
        cycles(2);
        // Overflow wraps to zero with carry.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);
        chk("wrap_acc", acc, 0);
        issue(OP_SUB, 32'd5, 32'd7, 0);
        issue(OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
        cycles(2);
        // Accumulator chain 7, 17, 34.
        issue(OP_ADD, 32'd3, 32'd4, 0);
        issue(OP_ADD, 32'd0, 32'd10, 1);
        issue(OP_SHL, 32'd0, 32'd0, 1);
        chk("chain_acc", acc, 34);
        cycles(3);
        // Backpressure: third command waits until the consumer drains.
        rsp_ready = 0;
        issue(OP_OR, 32'h00F0, 32'h0F00, 0);
        issue(OP_NOT, 32'h1234_5678, 32'd0, 0);
        fork
            issue(OP_SHR, 32'h8000_0001, 32'd0, 1);
            begin cycles(5); rsp_ready = 1; end
        join
        cycles(4);
        // Reset with two buffered responses.
        rsp_ready = 0;
        issue(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        issue(OP_ADD, 32'd1, 32'd2, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_rsp_data", {rsp_result, rsp_carry, rsp_zero}, 0);
        acc_m = 0;
        cycles(2);
        rst_n = 1;
        rsp_ready = 1;
        cycles(5);
        // Random traffic with random consumer backpressure.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = ($urandom_range(0, 7) == 0) ? a : $urandom;
                    issue(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)));
                    cycles($urandom_range(0, 2));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1;
        for (int i = 0; i < 50 && exp_occ > 0; i++) cycles(1);
        chk("drain_done", exp_occ, 0);
        cycles(1);
`ifdef ALU_CMD_ENGINE_STATS_EN
        chk("op_count", op_count, pops);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
